sram_responder: RTL and testbench
=================================

# sram_responder

Clocked model of the external asynchronous SRAM, acting as the device end of the SRAM pin interface. It samples active-low chip-enable, output-enable and write-enable strobes, stores write data in an internal array, and drives the shared bidirectional data bus during reads. Reads return data after a fixed latency. The block sits on the board side of the SRAM controller's pins and serves as the FPGA-emulated memory in system simulation and bring-up builds. It also provides access counters and a sticky protocol-error flag for debug.

## Interface
- ADDR_W, 20, width of the SRAM address pins
- DATA_W, 32, width of the data bus
- DEPTH_LOG2, 10, log2 of the number of array words; only addr[DEPTH_LOG2-1:0] is used
- RD_LAT, 1, cycles from sampling a read strobe to driving data; legal range 1..3
- clk  in  1  clock; all pins sampled on the rising edge
- rst  in  1  reset; asynchronous, active-high
- sram_addr  in  ADDR_W  word address
- sram_ce_n  in  1  chip enable, active low
- sram_oe_n  in  1  output enable, active low
- sram_we_n  in  1  write enable, active low
- sram_data  inout  DATA_W  bus; driven only in RD_DRIVE, otherwise high-Z
- rd_count  out  16  completed reads, wraps at 16'hFFFF→0
- wr_count  out  16  committed writes, wraps
- proto_err  out  1  sticky; set on an illegal strobe combination

## Operation
- States: IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE, ERR_HOLD.
- IDLE:
  - ce_n=0, oe_n=0, we_n=1 → RD_WAIT. Load latency counter with RD_LAT-1 and latch the address.
  - ce_n=0, we_n=0, oe_n=1 → WR_ACTIVE. Latch address and data.
- RD_WAIT:
  - Counter decrements each cycle; at 0 → RD_DRIVE.
  - Strobe deasserted → IDLE.
  - Address change → reload the counter and relatch the address.
- RD_DRIVE:
  - Bus = array[latched addr].
  - Stays while ce_n=0, oe_n=0 and the address is unchanged.
  - Address change → RD_WAIT, with the bus released that cycle.
  - oe_n or ce_n high → IDLE, bus released.
  - rd_count increments once on each entry to RD_DRIVE.
- WR_ACTIVE:
  - Address and data are relatched every cycle we_n=0.
  - Sampled we_n=1 with ce_n=0 → commit the latched data to the array, wr_count++, → IDLE.
  - ce_n=1 while we_n=0 → abort with no commit, → IDLE.
- Conflict:
  - Any sampled cycle with ce_n=0, oe_n=0 and we_n=0 → proto_err=1 and → ERR_HOLD. Applies in every state.
  - In ERR_HOLD: no commit and bus high-Z; → IDLE once oe_n=1 and we_n=1.
- Write then immediate read of the same address returns the new data (commit precedes the RD_WAIT read).
- Addresses alias modulo 2^DEPTH_LOG2. Upper address bits are ignored.

## Timing
- Reset values: state IDLE, bus high-Z, rd_count=0, wr_count=0, proto_err=0.
- Reset does not clear the array. Simulation initialises the array to 0.
- Reset mid-write: no commit. Reset mid-read: bus high-Z immediately (asynchronous).
- Read: oe_n sampled low at edge N → bus valid from edge N+RD_LAT until the edge that samples oe_n high.
- Write: a we_n low pulse of at least 1 sampled cycle, then we_n high sampled at edge M → array updated at edge M, readable from edge M+1.
- Back-to-back reads on changing addresses: each new address costs RD_LAT cycles with the bus high-Z.
- Counter wrap: 16'hFFFF + 1 → 16'h0000, with no flag.

## Structure
- Shared package sram_pkg holds:
  - the state enum (IDLE, RD_WAIT, RD_DRIVE, WR_ACTIVE, ERR_HOLD)
  - the default ADDR_W and DATA_W constants
  - the RD_LAT legal-range constants
- One sub-module, sram_array: single-port, DATA_W × 2^DEPTH_LOG2, synchronous write, registered read. It maps to block RAM.
- The tri-state bus driver and the FSM live in sram_responder.

## Test plan
- Write 0xDEADBEEF to addr 0x00010 (we_n low 3 cycles, then high); read addr 0x00010 with RD_LAT=1 → bus=0xDEADBEEF one cycle after oe_n is sampled low; wr_count=1, rd_count=1.
- Read 0x00001 then 0x00002 with oe_n held low; array preloaded with 0x11111111 and 0x22222222 → bus shows 0x11111111, then high-Z for 1 cycle, then 0x22222222; rd_count=2.
- Write aborted by ce_n rising while we_n is low, data 0xCAFEF00D to addr 5 → read of addr 5 returns its old value; wr_count unchanged.
- Drive ce_n=0, oe_n=0, we_n=0 for one cycle → proto_err=1 and stays 1; bus high-Z; no write; after the strobes are released, normal reads work.
- Aliasing with DEPTH_LOG2=10: write 0xA5A5A5A5 to 0x00403 → read of 0x00003 returns 0xA5A5A5A5.
- Assert rst mid-write and mid-read → bus high-Z within the reset cycle, counters 0, the pending write not committed, and array contents retained.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared constants and state encoding for the clocked SRAM device model.
package sram_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;
  localparam int unsigned ST_W       = 3;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_RD_WAIT   = 3'd1;
  localparam state_t ST_RD_DRIVE  = 3'd2;
  localparam state_t ST_WR_ACTIVE = 3'd3;
  localparam state_t ST_ERR_HOLD  = 3'd4;

  // All three strobes low at once is never a legal SRAM cycle.
  function automatic logic strobe_clash(input logic ce_n, input logic oe_n, input logic we_n);
    return !ce_n && !oe_n && !we_n;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Single-port word array: synchronous write, registered read, no reset so it maps to block RAM.
module sram_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  we,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sram_responder.sv
// Device end of the asynchronous SRAM pin interface: strobe FSM, tri-state data bus,
// access counters and a sticky protocol-error flag.
module sram_responder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ce_n,
  input  logic              sram_oe_n,
  input  logic              sram_we_n,
  inout  wire logic [DATA_W-1:0] sram_data,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              proto_err
);

  // Out-of-range latencies are pinned to the nearest legal value.
  localparam int unsigned LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             rd_count_d, wr_count_d;
  logic                    proto_err_d;
  logic                    commit_c;
  logic                    bus_en;
  logic [DATA_W-1:0]       rdata;
  logic [DEPTH_LOG2-1:0]   addr_in;
  logic                    clash;
  logic                    unused_addr_hi;

  assign addr_in        = sram_addr[DEPTH_LOG2-1:0];
  assign unused_addr_hi = ^sram_addr[ADDR_W-1:DEPTH_LOG2];
  assign clash          = strobe_clash(sram_ce_n, sram_oe_n, sram_we_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_count  <= rd_count_d;
      wr_count  <= wr_count_d;
      proto_err <= proto_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rd_count_d  = rd_count;
    wr_count_d  = wr_count;
    proto_err_d = proto_err;
    commit_c    = 1'b0;

    if (clash) begin
      state_d     = ST_ERR_HOLD;
      proto_err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!sram_ce_n && !sram_oe_n && sram_we_n) begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_LOAD;
            addr_d  = addr_in;
          end else if (!sram_ce_n && !sram_we_n && sram_oe_n) begin
            state_d = ST_WR_ACTIVE;
            addr_d  = addr_in;
            wdata_d = sram_data;
          end
        end
        ST_RD_WAIT: begin
          if (sram_ce_n || sram_oe_n) begin
            state_d = ST_IDLE;
          end else if (addr_in != addr_q) begin
            cnt_d  = CNT_LOAD;
            addr_d = addr_in;
          end else if (cnt_q == '0) begin
            state_d    = ST_RD_DRIVE;
            rd_count_d = rd_count + 16'd1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_RD_DRIVE: begin
          if (sram_ce_n || sram_oe_n) begin
            state_d = ST_IDLE;
          end else if (addr_in != addr_q) begin
            state_d = ST_RD_WAIT;
            cnt_d   = CNT_LOAD;
            addr_d  = addr_in;
          end
        end
        ST_WR_ACTIVE: begin
          // ce_n rising before we_n aborts the write; we_n rising under ce_n commits it.
          if (sram_ce_n) begin
            state_d = ST_IDLE;
          end else if (!sram_we_n) begin
            addr_d  = addr_in;
            wdata_d = sram_data;
          end else begin
            commit_c   = 1'b1;
            wr_count_d = wr_count + 16'd1;
            state_d    = ST_IDLE;
          end
        end
        ST_ERR_HOLD: begin
          if (sram_oe_n && sram_we_n) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  sram_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .addr  (addr_q),
    .we    (commit_c),
    .wdata (wdata_q),
    .rdata (rdata)
  );

  // Bus enable decodes straight from the state register so reset releases it asynchronously.
  assign bus_en    = (state_q == ST_RD_DRIVE);
  assign sram_data = bus_en ? rdata : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: writes, reads, aborts, conflicts, aliasing and reset.
module tb_sram_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] addr;
  logic        ce_n, oe_n, we_n;
  logic [31:0] bus_val;
  logic        bus_drv;
  wire  [31:0] sram_data;
  logic [15:0] rd_count, wr_count;
  logic        proto_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign sram_data = bus_drv ? bus_val : 32'bz;

  sram_responder dut (
    .clk       (clk),
    .rst       (rst),
    .sram_addr (addr),
    .sram_ce_n (ce_n),
    .sram_oe_n (oe_n),
    .sram_we_n (we_n),
    .sram_data (sram_data),
    .rd_count  (rd_count),
    .wr_count  (wr_count),
    .proto_err (proto_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag, input int rd, input int wr, input logic err);
    check({tag, ".rd_count"}, {16'h0, rd_count}, 32'(rd));
    check({tag, ".wr_count"}, {16'h0, wr_count}, 32'(wr));
    check({tag, ".proto_err"}, 32'(proto_err), 32'(err));
  endtask

  // we_n low for n sampled cycles, then high for the committing edge, then ce_n released.
  task automatic wr(input logic [19:0] a, input logic [31:0] d, input int n);
    addr = a; bus_val = d; bus_drv = 1'b1;
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    repeat (n) tick;
    we_n = 1'b1;
    tick;
    ce_n = 1'b1; bus_drv = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [19:0] a, input logic [31:0] exp);
    addr = a; bus_drv = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    tick;
    check({tag, ".wait_hiz"}, 32'(dut.bus_en), 32'd0);
    tick;
    check({tag, ".drive"}, 32'(dut.bus_en), 32'd1);
    check({tag, ".data"}, sram_data, exp);
    oe_n = 1'b1; ce_n = 1'b1;
    tick;
    check({tag, ".release"}, 32'(dut.bus_en), 32'd0);
  endtask

  initial begin
    rst = 1'b1; addr = '0; ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    bus_val = '0; bus_drv = 1'b0;
    tick; tick;
    check("reset.bus", 32'(dut.bus_en), 32'd0);
    check_counts("reset", 0, 0, 1'b0);
    rst = 1'b0;
    tick;

    // Basic write then read, RD_LAT=1.
    wr(20'h00010, 32'hDEADBEEF, 3);
    rd_chk("basic", 20'h00010, 32'hDEADBEEF);
    check_counts("basic", 1, 1, 1'b0);

    // Back-to-back reads with oe_n held low across an address change.
    wr(20'h00001, 32'h11111111, 1);
    wr(20'h00002, 32'h22222222, 1);
    addr = 20'h00001; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    tick;
    tick;
    check("b2b.first", sram_data, 32'h11111111);
    tick;
    check("b2b.hold", sram_data, 32'h11111111);
    check("b2b.hold_cnt", {16'h0, rd_count}, 32'd2);
    addr = 20'h00002;
    tick;
    check("b2b.gap_hiz", 32'(dut.bus_en), 32'd0);
    tick;
    check("b2b.second", sram_data, 32'h22222222);
    ce_n = 1'b1; oe_n = 1'b1;
    tick;
    check_counts("b2b", 3, 3, 1'b0);

    // Write aborted by ce_n rising while we_n is still low.
    wr(20'h00005, 32'h55555555, 1);
    addr = 20'h00005; bus_val = 32'hCAFEF00D; bus_drv = 1'b1;
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick; tick;
    ce_n = 1'b1;
    tick;
    we_n = 1'b1; bus_drv = 1'b0;
    tick;
    check("abort.wr_count", {16'h0, wr_count}, 32'd4);
    rd_chk("abort", 20'h00005, 32'h55555555);

    // Strobe conflict: sticky error, no write, bus stays released.
    wr(20'h00007, 32'h77777777, 1);
    addr = 20'h00007; bus_val = 32'hBAD0BAD0; bus_drv = 1'b1;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
    tick;
    check("clash.err", 32'(proto_err), 32'd1);
    check("clash.hiz", 32'(dut.bus_en), 32'd0);
    we_n = 1'b1; bus_drv = 1'b0;
    tick;
    check("clash.hold_hiz", 32'(dut.bus_en), 32'd0);
    check("clash.no_commit", {16'h0, wr_count}, 32'd5);
    ce_n = 1'b1; oe_n = 1'b1;
    tick;
    rd_chk("clash", 20'h00007, 32'h77777777);
    check_counts("clash", 5, 5, 1'b1);

    // Upper address bits alias onto the 1K-word array.
    wr(20'h00403, 32'hA5A5A5A5, 2);
    rd_chk("alias", 20'h00003, 32'hA5A5A5A5);
    check_counts("alias", 6, 6, 1'b1);

    // Reset in the middle of a write: counters clear, write is dropped, array retained.
    addr = 20'h00010; bus_val = 32'h12345678; bus_drv = 1'b1;
    ce_n = 1'b0; oe_n = 1'b1; we_n = 1'b0;
    tick; tick;
    rst = 1'b1;
    #1;
    check("rst_wr.bus", 32'(dut.bus_en), 32'd0);
    check_counts("rst_wr", 0, 0, 1'b0);
    ce_n = 1'b1; we_n = 1'b1; bus_drv = 1'b0;
    tick;
    rst = 1'b0;
    tick;
    rd_chk("rst_wr", 20'h00010, 32'hDEADBEEF);
    check_counts("rst_wr_after", 1, 0, 1'b0);

    // Reset in the middle of a read releases the bus asynchronously.
    addr = 20'h00003; ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    tick; tick;
    check("rst_rd.drive", 32'(dut.bus_en), 32'd1);
    check("rst_rd.data", sram_data, 32'hA5A5A5A5);
    rst = 1'b1;
    #1;
    check("rst_rd.hiz", 32'(dut.bus_en), 32'd0);
    check("rst_rd.rd_count", {16'h0, rd_count}, 32'd0);
    ce_n = 1'b1; oe_n = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    rd_chk("post_rst", 20'h00403, 32'hA5A5A5A5);
    check_counts("final", 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
